// File: rtl/product_accumulator.sv
// Sums groups of ACC_COUNT unsigned products from a valid/ready stream
// and presents each group sum on a valid/ready output port.
module product_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_COUNT  = 4,
  localparam int PW        = 2 * DATA_WIDTH,
  localparam int ACC_WIDTH = PW + $clog2(ACC_COUNT),
  localparam int CW        = $clog2(ACC_COUNT) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 p_valid,
  input  logic [PW-1:0]        p_in,
  output logic                 p_ready,
  output logic                 sum_valid,
  output logic [ACC_WIDTH-1:0] sum_out,
  input  logic                 sum_ready,
  output logic [CW-1:0]        acc_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(ACC_COUNT - 1);

  logic [1:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic [ACC_WIDTH-1:0] r_sum;
  logic                 r_sum_valid;

  logic                 w_p_fire;
  logic [ACC_WIDTH-1:0] w_p_ext;
  logic [ACC_WIDTH-1:0] w_acc_next;

  // rst gates p_ready so nothing looks acceptable while in reset
  assign p_ready    = (r_state != S_HOLD) & ~clear & ~rst;
  assign w_p_fire   = p_valid & p_ready;
  assign w_p_ext    = {{(ACC_WIDTH-PW){1'b0}}, p_in};
  assign w_acc_next = r_acc + w_p_ext;

  assign sum_valid = r_sum_valid;
  assign sum_out   = r_sum;
  assign acc_cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_p_fire) begin
            r_acc   <= w_p_ext;
            r_cnt   <= CW'(1);
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_p_fire) begin
            if (r_cnt == LAST) begin
              r_sum       <= w_acc_next;
              r_sum_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= S_HOLD;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (sum_ready) begin
            r_sum_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_sum_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator at default parameters.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        p_valid;
  logic [15:0] p_in;
  logic        p_ready;
  logic        sum_valid;
  logic [17:0] sum_out;
  logic        sum_ready;
  logic [2:0]  acc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .p_valid   (p_valid),
    .p_in      (p_in),
    .p_ready   (p_ready),
    .sum_valid (sum_valid),
    .sum_out   (sum_out),
    .sum_ready (sum_ready),
    .acc_cnt   (acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    p_valid = 1'b1;
    p_in    = v;
    tick();
    p_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; p_valid = 1'b0; p_in = '0; sum_ready = 1'b1;
    #2;
    chk("rst_p_ready", p_ready, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_p_ready", p_ready, 1);

    // basic group
    push(10); chk("basic_cnt1", acc_cnt, 1);
    push(20); chk("basic_cnt2", acc_cnt, 2);
    push(30); chk("basic_cnt3", acc_cnt, 3);
    chk("basic_no_valid_yet", sum_valid, 0);
    push(40);
    chk("basic_valid", sum_valid, 1);
    chk("basic_sum", sum_out, 100);
    chk("basic_p_ready_low", p_ready, 0);
    chk("basic_cnt0", acc_cnt, 0);
    tick();
    chk("basic_valid_1cyc", sum_valid, 0);
    chk("basic_p_ready_back", p_ready, 1);

    // max values
    for (int i = 0; i < 4; i++) push(16'd65025);
    chk("max_valid", sum_valid, 1);
    chk("max_sum", sum_out, 260100);
    tick();

    // backpressure
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(5);
    chk("bp_valid", sum_valid, 1);
    chk("bp_sum", sum_out, 20);
    p_valid = 1'b1; p_in = 7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_p_ready", p_ready, 0);
      tick();
      chk("bp_hold_valid", sum_valid, 1);
      chk("bp_hold_sum", sum_out, 20);
      chk("bp_hold_cnt", acc_cnt, 0);
    end
    sum_ready = 1'b1;
    tick();
    chk("bp_release_valid", sum_valid, 0);
    chk("bp_release_cnt", acc_cnt, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_seven_cnt", acc_cnt, 3);
    tick();
    p_valid = 1'b0;
    chk("bp_seven_valid", sum_valid, 1);
    chk("bp_seven_sum", sum_out, 28);
    tick();

    // gapped input
    push(1); chk("gap_cnt1", acc_cnt, 1);
    push(2); chk("gap_cnt2", acc_cnt, 2);
    tick();  chk("gap_idle_cnt2", acc_cnt, 2);
    push(3); chk("gap_cnt3", acc_cnt, 3);
    p_in = 16'd999;
    tick(); tick(); tick();
    chk("gap_idle_cnt3", acc_cnt, 3);
    chk("gap_idle_valid", sum_valid, 0);
    push(4);
    chk("gap_valid", sum_valid, 1);
    chk("gap_sum", sum_out, 10);
    chk("gap_cnt0", acc_cnt, 0);
    tick();

    // clear mid-group
    push(5); push(6);
    chk("clr_cnt2", acc_cnt, 2);
    clear = 1'b1; p_valid = 1'b1; p_in = 9;
    #1;
    chk("clr_p_ready", p_ready, 0);
    tick();
    clear = 1'b0; p_valid = 1'b0;
    chk("clr_cnt0", acc_cnt, 0);
    chk("clr_valid", sum_valid, 0);
    for (int i = 0; i < 4; i++) push(1);
    chk("clr_sum", sum_out, 4);
    chk("clr_sum_valid", sum_valid, 1);
    tick();

    // clear in HOLD together with sum_ready
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(3);
    chk("clrh_valid", sum_valid, 1);
    chk("clrh_sum", sum_out, 12);
    clear = 1'b1; sum_ready = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clrh_dropped", sum_valid, 0);
    chk("clrh_cnt", acc_cnt, 0);
    chk("clrh_p_ready", p_ready, 1);

    // async reset mid-group
    push(9); push(9); push(9);
    chk("arst_cnt3", acc_cnt, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", acc_cnt, 0);
    chk("arst_valid", sum_valid, 0);
    chk("arst_sum", sum_out, 0);
    chk("arst_p_ready", p_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_rel_p_ready", p_ready, 1);
    for (int i = 0; i < 4; i++) push(2);
    chk("arst_valid_after", sum_valid, 1);
    chk("arst_sum_after", sum_out, 8);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
